// File: rtl/vc_plane_scheduler_pkg.sv
// vc_plane_scheduler_pkg: shared mode constants, FSM states and weight helper for the VC plane scheduler
package vc_plane_scheduler_pkg;

    localparam int MODE_TDM = 0;
    localparam int MODE_WRR = 1;
    localparam int MAX_VC   = 32;

    typedef enum logic {IDLE, GRANT} state_t;

    // Extract the 8-bit budget of plane i; a zero weight still earns one cycle
    function automatic logic [7:0] weight_of(input logic [8*MAX_VC-1:0] weights, input int i);
        logic [7:0] w;
        w = weights[8*i +: 8];
        return (w == 8'd0) ? 8'd1 : w;
    endfunction

endpackage

// File: rtl/vc_plane_scheduler_rr_pick.sv
// vc_rr_pick: combinational cyclic priority picker, first request at or after start wins
module vc_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [IW-1:0] idx;

    // Walk from the farthest position back to start so the closest request overwrites the rest
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = IW'((int'(start) + k) % N);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/vc_plane_scheduler.sv
// vc_plane_scheduler: drives the one-hot VC plane selector in fixed TDM or weighted work-conserving mode
module vc_plane_scheduler
    import vc_plane_scheduler_pkg::*;
#(
    parameter int            VC          = 4,
    parameter int            MODE        = 0,
    parameter int            SLOT_CYCLES = 1,
    parameter logic [8*VC-1:0] VC_WEIGHTS = '0,
    parameter int            MAX_HOLD    = 64,
    localparam int IW = $clog2(VC),
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1,
    localparam int HW = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [VC-1:0] vc_pending,
    input  logic [VC-1:0] vc_lock,
    output logic [VC:0]   VCPlaneSelector,
    output logic [IW-1:0] plane_index,
    output logic          plane_switch,
    output logic          hold_violation
);

    localparam int              WL        = 8 * MAX_VC;
    localparam logic [WL-1:0]   WEIGHTS   = WL'(VC_WEIGHTS);
    localparam logic [VC:0]     IDLE_SEL  = {1'b1, {VC{1'b0}}};
    localparam logic [VC:0]     RESET_SEL = (MODE == MODE_TDM) ? {{VC{1'b0}}, 1'b1} : IDLE_SEL;

    state_t        state;
    logic [IW-1:0] last;
    logic [7:0]    budget;
    logic [HW-1:0] hold;
    logic [SW-1:0] slot;

    logic [IW-1:0] base;
    logic [IW-1:0] start;
    logic [VC-1:0] pick_gnt;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [7:0]    pick_w;
    logic          lock_g;
    logic          pend_g;
    logic          hold_hit;
    logic          slot_end;
    logic          slot_wrap;

    // Search resumes after the granted plane, or after the last one served when idle
    assign base      = (state == GRANT) ? plane_index : last;
    assign start     = (base == IW'(VC - 1)) ? '0 : base + IW'(1);
    assign lock_g    = vc_lock[plane_index];
    assign pend_g    = vc_pending[plane_index];
    assign hold_hit  = hold == HW'(MAX_HOLD - 1);
    assign slot_end  = (state == GRANT) && (((budget <= 8'd1) && !lock_g) || (!pend_g && !lock_g) || hold_hit);
    assign slot_wrap = slot == SW'(SLOT_CYCLES - 1);
    assign pick_w    = weight_of(WEIGHTS, int'(pick_idx));

    vc_rr_pick #(.N(VC)) u_pick (
        .req   (vc_pending),
        .start (start),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    // Binary index of the picked plane
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < VC; i++)
            if (pick_gnt[i]) pick_idx = IW'(i);
    end

    // Scheduler state and registered outputs for both modes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            last            <= IW'(VC - 1);
            budget          <= '0;
            hold            <= '0;
            slot            <= '0;
            VCPlaneSelector <= RESET_SEL;
            plane_index     <= '0;
            plane_switch    <= 1'b0;
            hold_violation  <= 1'b0;
        end else if (MODE == MODE_TDM) begin
            slot           <= slot_wrap ? '0 : slot + SW'(1);
            plane_switch   <= slot_wrap;
            hold_violation <= 1'b0;
            if (slot_wrap) begin
                VCPlaneSelector <= {1'b0, VCPlaneSelector[VC-2:0], VCPlaneSelector[VC-1]};
                plane_index     <= (plane_index == IW'(VC - 1)) ? '0 : plane_index + IW'(1);
            end
        end else begin
            plane_switch   <= 1'b0;
            hold_violation <= slot_end && hold_hit && lock_g;
            if (state == IDLE || slot_end) begin
                if (state == GRANT) last <= plane_index;
                if (pick_valid) begin
                    state           <= GRANT;
                    VCPlaneSelector <= {1'b0, pick_gnt};
                    plane_index     <= pick_idx;
                    budget          <= pick_w;
                    hold            <= '0;
                    plane_switch    <= (state == IDLE) || (pick_idx != plane_index);
                end else begin
                    state           <= IDLE;
                    VCPlaneSelector <= IDLE_SEL;
                    plane_index     <= '0;
                    plane_switch    <= state == GRANT;
                end
            end else begin
                budget <= (budget == 8'd0) ? 8'd0 : budget - 8'd1;
                hold   <= (hold == HW'(MAX_HOLD)) ? hold : hold + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vc_plane_scheduler.sv
// tb_vc_plane_scheduler: randomized and directed checks of both scheduler modes against a cycle-level model
module tb_vc_plane_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pend = '0;
    logic [3:0] lock = '0;

    logic [4:0] sel_t, sel_a, sel_b;
    logic [1:0] idx_t, idx_a, idx_b;
    logic       sw_t, sw_a, sw_b, hv_t, hv_a, hv_b;
    logic [8:0] obs_t, obs_a, obs_b;

    int vectors = 0;
    int miscompares = 0;

    int   m_cur [2];
    int   m_last[2];
    int   m_used[2];
    logic m_sw  [2];
    logic m_hv  [2];
    int   tdm_n;
    int   wt[2][4] = '{'{1, 3, 1, 1}, '{2, 1, 2, 4}};
    int   mh[2]    = '{8, 6};

    always #5 clk = ~clk;

    assign obs_t = {sel_t, idx_t, sw_t, hv_t};
    assign obs_a = {sel_a, idx_a, sw_a, hv_a};
    assign obs_b = {sel_b, idx_b, sw_b, hv_b};

    vc_plane_scheduler #(.VC(4), .MODE(0), .SLOT_CYCLES(2)) u_tdm (
        .clk(clk), .rst(rst), .vc_pending(pend), .vc_lock(lock),
        .VCPlaneSelector(sel_t), .plane_index(idx_t), .plane_switch(sw_t), .hold_violation(hv_t)
    );

    vc_plane_scheduler #(.VC(4), .MODE(1), .VC_WEIGHTS(32'h00010301), .MAX_HOLD(8)) u_wrr (
        .clk(clk), .rst(rst), .vc_pending(pend), .vc_lock(lock),
        .VCPlaneSelector(sel_a), .plane_index(idx_a), .plane_switch(sw_a), .hold_violation(hv_a)
    );

    vc_plane_scheduler #(.VC(4), .MODE(1), .VC_WEIGHTS(32'h04020102), .MAX_HOLD(6)) u_wrr2 (
        .clk(clk), .rst(rst), .vc_pending(pend), .vc_lock(lock),
        .VCPlaneSelector(sel_b), .plane_index(idx_b), .plane_switch(sw_b), .hold_violation(hv_b)
    );

    function automatic int find(input logic [3:0] r, input int from);
        for (int j = 0; j < 4; j++)
            if (r[(from + j) % 4]) return (from + j) % 4;
        return -1;
    endfunction

    function automatic logic [8:0] exp_wrr(input int k);
        logic [4:0] s;
        logic [1:0] i;
        s = (m_cur[k] < 0) ? 5'b10000 : 5'(1 << m_cur[k]);
        i = (m_cur[k] < 0) ? 2'd0 : 2'(m_cur[k]);
        return {s, i, m_sw[k], m_hv[k]};
    endfunction

    function automatic logic [8:0] exp_tdm();
        int p;
        p = (tdm_n / 2) % 4;
        return {5'(1 << p), 2'(p), (tdm_n > 0) && (tdm_n % 2 == 0), 1'b0};
    endfunction

    // One clock of the weighted scheduler, in terms of cycles already spent on the granted plane
    function automatic void model_step(input int k);
        int g, p;
        m_sw[k] = 1'b0;
        m_hv[k] = 1'b0;
        if (m_cur[k] < 0) begin
            p = find(pend, m_last[k] + 1);
            if (p >= 0) begin
                m_cur[k]  = p;
                m_used[k] = 1;
                m_sw[k]   = 1'b1;
            end
        end else begin
            g = m_cur[k];
            if ((!lock[g] && (m_used[k] >= wt[k][g] || !pend[g])) || m_used[k] >= mh[k]) begin
                m_hv[k]   = lock[g] && (m_used[k] >= mh[k]);
                p         = find(pend, g + 1);
                m_last[k] = g;
                m_sw[k]   = p != g;
                m_cur[k]  = p;
                m_used[k] = 1;
            end else begin
                m_used[k]++;
            end
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cur[k]  = -1;
            m_last[k] = 3;
            m_used[k] = 0;
            m_sw[k]   = 1'b0;
            m_hv[k]   = 1'b0;
        end
        tdm_n = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b0;
        pend = '0;
        lock = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick(input logic [3:0] p, input logic [3:0] l);
        pend = p;
        lock = l;
        model_step(0);
        model_step(1);
        tdm_n++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs_t !== 9'b00001_00_0_0) begin
            miscompares++;
            $display("FAIL reset_tdm: got %b want %b", obs_t, 9'b00001_00_0_0);
        end
        vectors++;
        if (obs_a !== 9'b10000_00_0_0) begin
            miscompares++;
            $display("FAIL reset_wrr: got %b want %b", obs_a, 9'b10000_00_0_0);
        end
        vectors++;
        if (obs_b !== 9'b10000_00_0_0) begin
            miscompares++;
            $display("FAIL reset_wrr2: got %b want %b", obs_b, 9'b10000_00_0_0);
        end
        vectors++;
        if (u_wrr.budget !== 8'd0 || u_wrr.hold !== 4'd0 || u_wrr.last !== 2'd3) begin
            miscompares++;
            $display("FAIL reset_counters: got budget %0d hold %0d last %0d want 0 0 3", u_wrr.budget, u_wrr.hold, u_wrr.last);
        end
    endtask

    task automatic test_tdm();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick(4'($urandom), 4'($urandom));
            vectors++;
            if (obs_t !== exp_tdm()) begin
                miscompares++;
                $display("FAIL tdm cyc %0d: got %b want %b", c, obs_t, exp_tdm());
            end
        end
    endtask

    task automatic test_wrr_sequence();
        int seq[12] = '{0, 1, 1, 1, 2, 3, 0, 1, 1, 1, 2, 3};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick(4'hF, 4'h0);
            vectors++;
            if (obs_a !== exp_wrr(0) || idx_a !== 2'(seq[c])) begin
                miscompares++;
                $display("FAIL wrr_seq cyc %0d: got %b want %b idx %0d", c, obs_a, exp_wrr(0), seq[c]);
            end
            vectors++;
            if (obs_b !== exp_wrr(1)) begin
                miscompares++;
                $display("FAIL wrr_seq_b cyc %0d: got %b want %b", c, obs_b, exp_wrr(1));
            end
        end
    endtask

    task automatic test_single_pending();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            tick(4'b0100, 4'h0);
            vectors++;
            if (obs_b !== exp_wrr(1) || {sel_b, sw_b} !== {5'b00100, c == 0}) begin
                miscompares++;
                $display("FAIL single_pending cyc %0d: got %b want %b", c, obs_b, exp_wrr(1));
            end
        end
        tick(4'b0000, 4'h0);
        vectors++;
        if (obs_b !== exp_wrr(1) || {sel_b, sw_b} !== 6'b10000_1) begin
            miscompares++;
            $display("FAIL single_pending_idle: got %b want %b", obs_b, exp_wrr(1));
        end
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            tick(4'b0011, (c < 5) ? 4'b0001 : 4'b0000);
            vectors++;
            if (obs_a !== exp_wrr(0) || (c <= 6 && idx_a !== ((c < 5) ? 2'd0 : 2'd1))) begin
                miscompares++;
                $display("FAIL lock cyc %0d: got %b want %b", c, obs_a, exp_wrr(0));
            end
        end
    endtask

    task automatic test_hold();
        int hv_cnt = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            tick(4'b0011, 4'b0001);
            hv_cnt += int'(hv_a);
            vectors++;
            if (obs_a !== exp_wrr(0) || (c == 8 && {idx_a, hv_a} !== 3'b01_1)) begin
                miscompares++;
                $display("FAIL hold cyc %0d: got %b want %b", c, obs_a, exp_wrr(0));
            end
            vectors++;
            if (obs_b !== exp_wrr(1)) begin
                miscompares++;
                $display("FAIL hold_b cyc %0d: got %b want %b", c, obs_b, exp_wrr(1));
            end
        end
        vectors++;
        if (hv_cnt != 1) begin
            miscompares++;
            $display("FAIL hold_pulses: got %0d want 1", hv_cnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        for (int c = 0; c < 3; c++) tick(4'hF, 4'h0);
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({sel_a, idx_a, sel_t} !== {5'b10000, 2'd0, 5'b00001} || u_wrr.budget !== 8'd0 || u_wrr.hold !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_grant: got sel %b idx %0d tdm %b budget %0d hold %0d want 10000 0 00001 0 0",
                     sel_a, idx_a, sel_t, u_wrr.budget, u_wrr.hold);
        end
        do_reset();
        tick(4'hF, 4'h0);
        vectors++;
        if (obs_a !== exp_wrr(0) || idx_a !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_regrant: got %b want %b", obs_a, exp_wrr(0));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            tick(4'($urandom), 4'($urandom & $urandom));
            vectors++;
            if (obs_a !== exp_wrr(0)) begin
                miscompares++;
                $display("FAIL random_a cyc %0d: got %b want %b", c, obs_a, exp_wrr(0));
            end
            vectors++;
            if (obs_b !== exp_wrr(1)) begin
                miscompares++;
                $display("FAIL random_b cyc %0d: got %b want %b", c, obs_b, exp_wrr(1));
            end
            vectors++;
            if (obs_t !== exp_tdm()) begin
                miscompares++;
                $display("FAIL random_tdm cyc %0d: got %b want %b", c, obs_t, exp_tdm());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_tdm();
        test_wrr_sequence();
        test_single_pending();
        test_lock();
        test_hold();
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
